// File: rtl/extract_channel_stream.sv
// rtl/extract_channel_stream.sv - extracts one channel from an interleaved item stream and repacks it
module extract_channel_stream #(
  parameter int TDATA_WIDTH   = 256,
  parameter int ITEM_WIDTH    = 8,
  parameter int CHANNEL_COUNT = 3
) (
  input  logic                             axis_aclk,
  input  logic                             axis_reset,
  input  logic [$clog2(CHANNEL_COUNT):0]   channel_select,
  input  logic [TDATA_WIDTH-1:0]           s_axis_tdata,
  input  logic [TDATA_WIDTH/8-1:0]         s_axis_tkeep,
  input  logic                             s_axis_tvalid,
  input  logic                             s_axis_tlast,
  output logic                             s_axis_tready,
  output logic [TDATA_WIDTH-1:0]           m_axis_tdata,
  output logic [TDATA_WIDTH/8-1:0]         m_axis_tkeep,
  output logic                             m_axis_tvalid,
  output logic                             m_axis_tlast,
  input  logic                             m_axis_tready
);

  localparam int ITEM_COUNT = TDATA_WIDTH / ITEM_WIDTH;
  localparam int KEEP_WIDTH = TDATA_WIDTH / 8;
  localparam int ITEM_BYTES = ITEM_WIDTH / 8;
  localparam int ACC_ITEMS  = 2 * ITEM_COUNT - 1;
  localparam int ACC_WIDTH  = ACC_ITEMS * ITEM_WIDTH;
  localparam int CNT_W      = $clog2(2 * ITEM_COUNT);
  localparam int SEL_W      = $clog2(CHANNEL_COUNT) + 1;

  typedef enum logic {RUN, FLUSH} state_t;

  state_t             state, state_next;
  logic [ACC_WIDTH-1:0]   acc;
  logic [CNT_W-1:0]       acc_count;
  logic [SEL_W-1:0]       phase;
  logic [SEL_W-1:0]       sel_q;
  logic                   in_packet;

  logic [SEL_W-1:0]       sel_eff;
  logic [SEL_W-1:0]       ch;
  logic [SEL_W-1:0]       next_phase;
  logic [TDATA_WIDTH-1:0] new_items;
  logic [CNT_W-1:0]       new_count;
  logic [ACC_WIDTH-1:0]   combined;
  logic [CNT_W-1:0]       total;
  logic                   in_accept;
  logic                   out_accept;

  // tkeep mask covering the lowest n items
  function automatic logic [KEEP_WIDTH-1:0] keep_for(input logic [CNT_W-1:0] n);
    logic [KEEP_WIDTH-1:0] k;
    k = '0;
    for (int i = 0; i < ITEM_COUNT; i++) begin
      if (CNT_W'(i) < n) k[i*ITEM_BYTES +: ITEM_BYTES] = '1;
    end
    return k;
  endfunction

  assign s_axis_tready = !axis_reset && (state == RUN) && (!m_axis_tvalid || m_axis_tready);
  assign in_accept     = s_axis_tvalid && s_axis_tready;
  assign out_accept    = m_axis_tvalid && m_axis_tready;

  // Pick the selected channel's items out of the beat and append them behind the accumulator
  always_comb begin
    sel_eff   = in_packet ? sel_q : channel_select;
    new_items = '0;
    new_count = '0;
    ch        = phase;
    for (int i = 0; i < ITEM_COUNT; i++) begin
      if (&s_axis_tkeep[i*ITEM_BYTES +: ITEM_BYTES]) begin
        if (ch == sel_eff) begin
          new_items[new_count*ITEM_WIDTH +: ITEM_WIDTH] = s_axis_tdata[i*ITEM_WIDTH +: ITEM_WIDTH];
          new_count = new_count + 1'b1;
        end
        ch = (ch == SEL_W'(CHANNEL_COUNT - 1)) ? '0 : ch + 1'b1;
      end
    end
    next_phase = ch;
    combined   = acc | (ACC_WIDTH'(new_items) << (acc_count * ITEM_WIDTH));
    total      = acc_count + new_count;
  end

  // State register
  always_ff @(posedge axis_aclk or posedge axis_reset) begin
    if (axis_reset) state <= RUN;
    else            state <= state_next;
  end

  // FLUSH is entered when a packet ends with more than one beat's worth of items pending
  always_comb begin
    state_next = state;
    case (state)
      RUN:     if (in_accept && s_axis_tlast && (total > CNT_W'(ITEM_COUNT))) state_next = FLUSH;
      FLUSH:   if (out_accept && m_axis_tlast) state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  // Accumulator, packet tracking and registered output beat
  always_ff @(posedge axis_aclk or posedge axis_reset) begin
    if (axis_reset) begin
      acc           <= '0;
      acc_count     <= '0;
      phase         <= '0;
      sel_q         <= '0;
      in_packet     <= 1'b0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tlast  <= 1'b0;
    end else begin
      if (out_accept) m_axis_tvalid <= 1'b0;
      if (state == FLUSH) begin
        if (out_accept && !m_axis_tlast) begin
          m_axis_tdata  <= acc[TDATA_WIDTH-1:0];
          m_axis_tkeep  <= keep_for(acc_count);
          m_axis_tlast  <= 1'b1;
          m_axis_tvalid <= 1'b1;
          acc           <= '0;
          acc_count     <= '0;
        end
      end else if (in_accept) begin
        if (s_axis_tlast) begin
          in_packet     <= 1'b0;
          phase         <= '0;
          m_axis_tvalid <= 1'b1;
          m_axis_tdata  <= combined[TDATA_WIDTH-1:0];
          if (total > CNT_W'(ITEM_COUNT)) begin
            m_axis_tkeep <= '1;
            m_axis_tlast <= 1'b0;
            acc          <= combined >> TDATA_WIDTH;
            acc_count    <= total - CNT_W'(ITEM_COUNT);
          end else begin
            m_axis_tkeep <= keep_for(total);
            m_axis_tlast <= 1'b1;
            acc          <= '0;
            acc_count    <= '0;
          end
        end else begin
          in_packet <= 1'b1;
          sel_q     <= sel_eff;
          phase     <= next_phase;
          if (total >= CNT_W'(ITEM_COUNT)) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= combined[TDATA_WIDTH-1:0];
            m_axis_tkeep  <= '1;
            m_axis_tlast  <= 1'b0;
            acc           <= combined >> TDATA_WIDTH;
            acc_count     <= total - CNT_W'(ITEM_COUNT);
          end else begin
            acc       <= combined;
            acc_count <= total;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_extract_channel_stream.sv
// tb/tb_extract_channel_stream.sv - self-checking bench for extract_channel_stream
module tb_extract_channel_stream;

  logic        clk = 1'b0;
  logic        axis_reset;
  logic [2:0]  channel_select;
  logic [31:0] s_axis_tdata;
  logic [3:0]  s_axis_tkeep;
  logic        s_axis_tvalid;
  logic        s_axis_tlast;
  logic        s_axis_tready;
  logic [31:0] m_axis_tdata;
  logic [3:0]  m_axis_tkeep;
  logic        m_axis_tvalid;
  logic        m_axis_tlast;
  logic        m_axis_tready;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
  } beat_t;

  typedef struct {
    int              sel;
    int              nb;
    logic [7:0][3:0] keeps;
    int              n_exp;
    logic [1:0][31:0] ed;
    logic [1:0][3:0]  ek;
    logic [1:0]       el;
  } vec_t;

  beat_t exp_q[$];
  int    checks = 0;
  int    fails  = 0;
  bit    rand_ready = 1'b0;
  int    cyc = 0;

  extract_channel_stream #(.TDATA_WIDTH(32), .ITEM_WIDTH(8), .CHANNEL_COUNT(3)) dut (
    .axis_aclk(clk), .axis_reset(axis_reset), .channel_select(channel_select),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Output monitor: scoreboard compare on handshake, stability while stalled
  initial begin : monitor
    beat_t held;
    beat_t e;
    bit    stalled;
    stalled = 1'b0;
    forever begin
      @(negedge clk);
      if (axis_reset) begin
        stalled = 1'b0;
      end else begin
        if (stalled) begin
          check("stall_valid", 32'(m_axis_tvalid), 32'd1);
          check("stall_data", m_axis_tdata, held.data);
          check("stall_keep", 32'(m_axis_tkeep), 32'(held.keep));
          check("stall_last", 32'(m_axis_tlast), 32'(held.last));
        end
        if (m_axis_tvalid && m_axis_tready) begin
          if (exp_q.size() == 0) begin
            checks++;
            fails++;
            $display("FAIL unexpected_beat: got data %h keep %h last %0d, expected no beat",
                     m_axis_tdata, m_axis_tkeep, m_axis_tlast);
          end else begin
            e = exp_q.pop_front();
            check("out_data", m_axis_tdata, e.data);
            check("out_keep", 32'(m_axis_tkeep), 32'(e.keep));
            check("out_last", 32'(m_axis_tlast), 32'(e.last));
          end
        end
        stalled   = m_axis_tvalid && !m_axis_tready;
        held.data = m_axis_tdata;
        held.keep = m_axis_tkeep;
        held.last = m_axis_tlast;
      end
    end
  end

  // Random output backpressure when enabled
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) m_axis_tready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l, input logic [2:0] sel);
    int n;
    n = 0;
    s_axis_tdata   = d;
    s_axis_tkeep   = k;
    s_axis_tlast   = l;
    channel_select = sel;
    s_axis_tvalid  = 1'b1;
    forever begin
      @(negedge clk);
      if (s_axis_tready) break;
      n++;
      if (n > 1000) begin
        checks++;
        fails++;
        $display("FAIL send_timeout: s_axis_tready stayed 0, expected 1");
        break;
      end
    end
    @(posedge clk);
    #1;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic push_beat(input logic [7:0] ext[$], input int idx, input int n, input bit last);
    beat_t b;
    b.data = '0;
    b.keep = '0;
    for (int j = 0; j < n; j++) begin
      b.data[j*8 +: 8] = ext[idx + j];
      b.keep[j]        = 1'b1;
    end
    b.last = last;
    exp_q.push_back(b);
  endtask

  // Reference: item k goes to channel k%3; output chunks of 4, the final chunk carries tlast
  task automatic model_push(input logic [7:0] items[$], input int nbefore, input int sel);
    logic [7:0] ext[$];
    int ext_before, full, idx, r;
    ext_before = 0;
    for (int k = 0; k < items.size(); k++) begin
      if (k % 3 == sel) begin
        ext.push_back(items[k]);
        if (k < nbefore) ext_before++;
      end
    end
    full = ext_before / 4;
    for (int f = 0; f < full; f++) push_beat(ext, f * 4, 4, 1'b0);
    idx = full * 4;
    r   = ext.size() - idx;
    if (r > 4) begin
      push_beat(ext, idx, 4, 1'b0);
      idx += 4;
      r   -= 4;
    end
    push_beat(ext, idx, r, 1'b1);
  endtask

  task automatic send_pkt(input int sel, input int nb, input logic [7:0][3:0] keeps,
                          input bit rnd, input bit use_model);
    logic [7:0]  items[$];
    logic [31:0] data[8];
    logic [7:0]  x;
    int nbefore, v, selb;
    nbefore = 0;
    v = 0;
    for (int b = 0; b < nb; b++) begin
      for (int j = 0; j < 4; j++) begin
        if (keeps[b][j]) begin
          x = rnd ? 8'($urandom) : 8'(v);
          v++;
          items.push_back(x);
        end else begin
          x = rnd ? 8'($urandom) : 8'hEE;
        end
        data[b][j*8 +: 8] = x;
      end
      if (b == nb - 2) nbefore = items.size();
    end
    if (use_model) model_push(items, nbefore, sel);
    for (int b = 0; b < nb; b++) begin
      selb = (b == 0 || !rnd) ? sel : int'($urandom_range(0, 4));
      send_beat(data[b], keeps[b], b == nb - 1, 3'(selb));
      if (rnd && $urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL %s: %0d beats still pending, expected 0", name, exp_q.size());
      exp_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [31:0] d, input logic [3:0] k, input logic l);
    beat_t b;
    b.data = d;
    b.keep = k;
    b.last = l;
    exp_q.push_back(b);
  endtask

  vec_t tbl[10];

  initial begin
    int c0, nbk, kc;
    logic [7:0][3:0] keeps;

    tbl[0] = '{sel:0, nb:3, keeps:32'h0000_0FFF, n_exp:1, ed:{32'h0, 32'h0906_0300}, ek:{4'h0, 4'hF}, el:2'b01};
    tbl[1] = '{sel:2, nb:3, keeps:32'h0000_0FFF, n_exp:1, ed:{32'h0, 32'h0B08_0502}, ek:{4'h0, 4'hF}, el:2'b01};
    tbl[2] = '{sel:1, nb:2, keeps:32'h0000_007F, n_exp:1, ed:{32'h0, 32'h0000_0401}, ek:{4'h0, 4'h3}, el:2'b01};
    tbl[3] = '{sel:3, nb:1, keeps:32'h0000_000F, n_exp:1, ed:{32'h0, 32'h0000_0000}, ek:{4'h0, 4'h0}, el:2'b01};
    tbl[4] = '{sel:0, nb:4, keeps:32'h0000_F1FF, n_exp:2, ed:{32'h0000_000C, 32'h0906_0300}, ek:{4'h1, 4'hF}, el:2'b10};
    tbl[5] = '{sel:0, nb:4, keeps:32'h0000_0FFF, n_exp:2, ed:{32'h0000_0000, 32'h0906_0300}, ek:{4'h0, 4'hF}, el:2'b10};
    tbl[6] = '{sel:1, nb:1, keeps:32'h0000_0000, n_exp:1, ed:{32'h0, 32'h0000_0000}, ek:{4'h0, 4'h0}, el:2'b01};
    tbl[7] = '{sel:1, nb:3, keeps:32'h0000_0FFF, n_exp:1, ed:{32'h0, 32'h0A07_0401}, ek:{4'h0, 4'hF}, el:2'b01};
    tbl[8] = '{sel:0, nb:1, keeps:32'h0000_000F, n_exp:1, ed:{32'h0, 32'h0000_0300}, ek:{4'h0, 4'h3}, el:2'b01};
    tbl[9] = '{sel:2, nb:2, keeps:32'h0000_003F, n_exp:1, ed:{32'h0, 32'h0000_0502}, ek:{4'h0, 4'h3}, el:2'b01};

    axis_reset     = 1'b1;
    channel_select = '0;
    s_axis_tdata   = '0;
    s_axis_tkeep   = '0;
    s_axis_tvalid  = 1'b0;
    s_axis_tlast   = 1'b0;
    m_axis_tready  = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_m_tvalid", 32'(m_axis_tvalid), 32'd0);
    check("rst_m_tdata", m_axis_tdata, 32'd0);
    check("rst_m_tkeep", 32'(m_axis_tkeep), 32'd0);
    check("rst_m_tlast", 32'(m_axis_tlast), 32'd0);
    check("rst_s_tready", 32'(s_axis_tready), 32'd0);
    @(posedge clk);
    #1;
    axis_reset = 1'b0;
    @(posedge clk);
    #1;

    // Directed vectors
    for (int t = 0; t < 10; t++) begin
      for (int e = 0; e < tbl[t].n_exp; e++) push_exp(tbl[t].ed[e], tbl[t].ek[e], tbl[t].el[e]);
      send_pkt(tbl[t].sel, tbl[t].nb, tbl[t].keeps, 1'b0, 1'b0);
      wait_drain($sformatf("vec%0d_drain", t));
    end

    // Back-to-back packets with no bubble between them
    push_exp(32'h0906_0300, 4'hF, 1'b1);
    push_exp(32'h0B08_0502, 4'hF, 1'b1);
    c0 = cyc;
    send_pkt(0, 3, 32'h0000_0FFF, 1'b0, 1'b0);
    send_pkt(2, 3, 32'h0000_0FFF, 1'b0, 1'b0);
    check("throughput_cycles", 32'(cyc - c0), 32'd6);
    wait_drain("b2b_drain");

    // Output stall while second output beat pending
    m_axis_tready = 1'b0;
    push_exp(32'h0906_0300, 4'hF, 1'b0);
    push_exp(32'h1512_0F0C, 4'hF, 1'b1);
    fork
      send_pkt(0, 6, 32'h00FF_FFFF, 1'b0, 1'b0);
    join_none
    nbk = 0;
    while (!m_axis_tvalid && nbk < 100) begin
      @(negedge clk);
      nbk++;
    end
    check("stall_valid_seen", 32'(m_axis_tvalid), 32'd1);
    repeat (4) begin
      @(negedge clk);
      check("stall_s_tready", 32'(s_axis_tready), 32'd0);
    end
    @(posedge clk);
    #1;
    m_axis_tready = 1'b1;
    wait_drain("stall_drain");
    repeat (3) @(posedge clk);
    #1;

    // Reset in the middle of a packet
    send_beat(32'h0302_0100, 4'hF, 1'b0, 3'd0);
    axis_reset = 1'b1;
    @(negedge clk);
    check("midrst_m_tvalid", 32'(m_axis_tvalid), 32'd0);
    check("midrst_m_tdata", m_axis_tdata, 32'd0);
    check("midrst_m_tkeep", 32'(m_axis_tkeep), 32'd0);
    check("midrst_m_tlast", 32'(m_axis_tlast), 32'd0);
    check("midrst_s_tready", 32'(s_axis_tready), 32'd0);
    @(posedge clk);
    #1;
    axis_reset = 1'b0;
    push_exp(32'h0906_0300, 4'hF, 1'b1);
    send_pkt(0, 3, 32'h0000_0FFF, 1'b0, 1'b0);
    wait_drain("postrst_drain");

    // Randomized packets against the reference model
    rand_ready = 1'b1;
    for (int p = 0; p < 150; p++) begin
      nbk = $urandom_range(1, 6);
      keeps = '0;
      for (int b = 0; b < nbk; b++) begin
        kc = $urandom_range(0, 6);
        if (kc > 4) kc = 4;
        keeps[b] = 4'((1 << kc) - 1);
      end
      send_pkt($urandom_range(0, 4), nbk, keeps, 1'b1, 1'b1);
    end
    wait_drain("random_drain");
    rand_ready = 1'b0;
    m_axis_tready = 1'b1;
    repeat (5) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
